// File: rtl/alu_unit.sv
// RV32I execution unit: computes integer/branch/jump results for issued ops and queues them
// in a 2-entry in-order FIFO until the CDB arbiter grants the head.
module alu_unit #(
  parameter int unsigned ROB_BIT  = 5,
  parameter int unsigned OQ_DEPTH = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               rob_clear_up,
  input  logic               start_alu,
  input  logic [31:0]        vi,
  input  logic [31:0]        vj,
  input  logic [31:0]        imm,
  input  logic [31:0]        inst_addr,
  input  logic [2:0]         op,
  input  logic [6:0]         op_type,
  input  logic               op_addition,
  input  logic [ROB_BIT-1:0] alu_rob_entry,
  output logic               alu_full,
  input  logic               cdb_grant,
  output logic               alu_ready,
  output logic [ROB_BIT-1:0] finished_alu_rob_entry,
  output logic [31:0]        alu_result,
  output logic [31:0]        next_pc,
  output logic               is_ctrl
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam int unsigned CW = $clog2(OQ_DEPTH + 1);

  logic [31:0] calc_res, calc_npc, pc4;
  logic        calc_ctrl, taken;
  logic [4:0]  sh;

  always_comb begin
    pc4       = inst_addr + 32'd4;
    sh        = vj[4:0];
    calc_res  = '0;
    calc_npc  = pc4;
    calc_ctrl = 1'b0;
    taken     = 1'b0;
    unique case (op_type)
      OPC_OP, OPC_OPIMM: begin
        unique case (op)
          3'b000: calc_res = (op_type == OPC_OP && op_addition) ? vi - vj : vi + vj;
          3'b001: calc_res = vi << sh;
          3'b010: calc_res = {31'b0, $signed(vi) < $signed(vj)};
          3'b011: calc_res = {31'b0, vi < vj};
          3'b100: calc_res = vi ^ vj;
          3'b101: calc_res = op_addition ? 32'($signed(vi) >>> sh) : vi >> sh;
          3'b110: calc_res = vi | vj;
          3'b111: calc_res = vi & vj;
          default: calc_res = '0;
        endcase
      end
      OPC_LUI:   calc_res = imm;
      OPC_AUIPC: calc_res = inst_addr + imm;
      OPC_BRANCH: begin
        calc_ctrl = 1'b1;
        unique case (op)
          3'b000: taken = (vi == vj);
          3'b001: taken = (vi != vj);
          3'b100: taken = ($signed(vi) < $signed(vj));
          3'b101: taken = ($signed(vi) >= $signed(vj));
          3'b110: taken = (vi < vj);
          3'b111: taken = (vi >= vj);
          default: taken = 1'b0;
        endcase
        calc_res = {31'b0, taken};
        calc_npc = taken ? inst_addr + imm : pc4;
      end
      OPC_JAL: begin
        calc_ctrl = 1'b1;
        calc_res  = pc4;
        calc_npc  = inst_addr + imm;
      end
      OPC_JALR: begin
        calc_ctrl = 1'b1;
        calc_res  = pc4;
        calc_npc  = (vi + imm) & ~32'h1;
      end
      default: ;
    endcase
  end

  logic [ROB_BIT-1:0] tag_q  [OQ_DEPTH];
  logic [31:0]        res_q  [OQ_DEPTH];
  logic [31:0]        npc_q  [OQ_DEPTH];
  logic               ctrl_q [OQ_DEPTH];
  logic               head_q, tail_q;
  logic [CW-1:0]      count_q;
  logic               accept, pop;

  assign alu_full  = (count_q == CW'(OQ_DEPTH));
  assign alu_ready = (count_q != '0);
  // full is taken from the registered count, so a same-cycle pop never frees a slot for a start
  assign accept    = start_alu && !alu_full && rdy_in && !rob_clear_up;
  assign pop       = cdb_grant && alu_ready && rdy_in && !rob_clear_up;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
      for (int unsigned i = 0; i < OQ_DEPTH; i++) begin
        tag_q[i]  <= '0;
        res_q[i]  <= '0;
        npc_q[i]  <= '0;
        ctrl_q[i] <= 1'b0;
      end
    end else if (rdy_in) begin
      if (rob_clear_up) begin
        head_q  <= 1'b0;
        tail_q  <= 1'b0;
        count_q <= '0;
      end else begin
        if (accept) begin
          tag_q[tail_q]  <= alu_rob_entry;
          res_q[tail_q]  <= calc_res;
          npc_q[tail_q]  <= calc_npc;
          ctrl_q[tail_q] <= calc_ctrl;
          tail_q         <= ~tail_q;
        end
        if (pop) head_q <= ~head_q;
        count_q <= count_q + CW'(accept) - CW'(pop);
      end
    end
  end

  assign finished_alu_rob_entry = tag_q[head_q];
  assign alu_result             = res_q[head_q];
  assign next_pc                = npc_q[head_q];
  assign is_ctrl                = ctrl_q[head_q];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      assert (!(start_alu && alu_full))
        else $warning("alu_unit: start_alu while alu_full, issue dropped");
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: directed and random issues checked against a reference model.
module tb_alu_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        s_rdy, s_flush, s_start, s_add, s_grant;
  logic [31:0] s_vi, s_vj, s_imm, s_pc;
  logic [2:0]  s_op;
  logic [6:0]  s_typ;
  logic [4:0]  s_tag;
  logic        alu_full, alu_ready, is_ctrl;
  logic [4:0]  fin_tag;
  logic [31:0] alu_result, next_pc;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] res;
    logic [31:0] npc;
    logic        ctrl;
  } exp_t;

  exp_t q[$];
  int   cur_cnt = 0;
  int   checks = 0;
  int   failures = 0;

  alu_unit #(.ROB_BIT(5), .OQ_DEPTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(s_rdy), .rob_clear_up(s_flush),
    .start_alu(s_start), .vi(s_vi), .vj(s_vj), .imm(s_imm), .inst_addr(s_pc),
    .op(s_op), .op_type(s_typ), .op_addition(s_add), .alu_rob_entry(s_tag),
    .alu_full(alu_full), .cdb_grant(s_grant), .alu_ready(alu_ready),
    .finished_alu_rob_entry(fin_tag), .alu_result(alu_result), .next_pc(next_pc),
    .is_ctrl(is_ctrl)
  );

  always #5 clk_in = ~clk_in;

  function automatic exp_t model(input logic [6:0] typ, input logic [2:0] f3, input logic add,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                                 input logic [31:0] pc, input logic [4:0] tag);
    exp_t e;
    logic [31:0] ones;
    int   amt;
    logic lt_s, lt_u, tk;
    ones  = '1;
    amt   = int'(b & 32'd31);
    lt_s  = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    lt_u  = a < b;
    e.tag = tag;
    e.res = 32'd0;
    e.npc = pc + 32'd4;
    e.ctrl = 1'b0;
    if (typ == 7'b0110011 || typ == 7'b0010011) begin
      case (f3)
        3'd0: e.res = (typ == 7'b0110011 && add) ? a + (~b + 32'd1) : a + b;
        3'd1: e.res = a << amt;
        3'd2: e.res = lt_s ? 32'd1 : 32'd0;
        3'd3: e.res = lt_u ? 32'd1 : 32'd0;
        3'd4: e.res = a ^ b;
        3'd5: begin
          e.res = a >> amt;
          if (add && a[31]) e.res = e.res | ~(ones >> amt);
        end
        3'd6: e.res = a | b;
        default: e.res = a & b;
      endcase
    end else if (typ == 7'b0110111) begin
      e.res = im;
    end else if (typ == 7'b0010111) begin
      e.res = pc + im;
    end else if (typ == 7'b1100011) begin
      case (f3)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = lt_s;
        3'd5: tk = !lt_s;
        3'd6: tk = lt_u;
        3'd7: tk = !lt_u;
        default: tk = 1'b0;
      endcase
      e.ctrl = 1'b1;
      e.res  = tk ? 32'd1 : 32'd0;
      if (tk) e.npc = pc + im;
    end else if (typ == 7'b1101111) begin
      e.ctrl = 1'b1;
      e.res  = pc + 32'd4;
      e.npc  = pc + im;
    end else if (typ == 7'b1100111) begin
      e.ctrl = 1'b1;
      e.res  = pc + 32'd4;
      e.npc  = (a + im) - ((a + im) % 2);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Apply the current inputs for one edge; the model decides accept/pop/flush.
  task automatic tick();
    bit acc, pp;
    int nxt;
    acc = s_start && cur_cnt != 2 && s_rdy && !s_flush;
    pp  = s_grant && cur_cnt != 0 && s_rdy && !s_flush;
    nxt = cur_cnt;
    if (s_rdy && s_flush) begin
      q.delete();
      nxt = 0;
    end else begin
      if (acc) q.push_back(model(s_typ, s_op, s_add, s_vi, s_vj, s_imm, s_pc, s_tag));
      nxt = cur_cnt + int'(acc) - int'(pp);
    end
    @(posedge clk_in);
    #2;
    cur_cnt = nxt;
  endtask

  task automatic issue(input logic [6:0] typ, input logic [2:0] f3, input logic add,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] pc, input logic [4:0] tag);
    s_start = 1'b1; s_typ = typ; s_op = f3; s_add = add;
    s_vi = a; s_vj = b; s_imm = im; s_pc = pc; s_tag = tag;
    tick();
    s_start = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands its head to the CDB.
  initial begin
    forever begin
      @(negedge clk_in);
      chk("alu_ready", {31'b0, alu_ready}, {31'b0, cur_cnt != 0});
      chk("alu_full", {31'b0, alu_full}, {31'b0, cur_cnt == 2});
      if (alu_ready && s_grant && s_rdy && !s_flush && rst_in) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual=ready required=empty t=%0t", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("tag", {27'b0, fin_tag}, {27'b0, e.tag});
          chk("result", alu_result, e.res);
          chk("next_pc", next_pc, e.npc);
          chk("is_ctrl", {31'b0, is_ctrl}, {31'b0, e.ctrl});
        end
      end
    end
  end

  initial begin
    logic [6:0] opcs [8];
    opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
             7'b1100011, 7'b1101111, 7'b1100111, 7'b0000011};
    rst_in = 1'b0; s_rdy = 1'b1; s_flush = 1'b0; s_start = 1'b0; s_add = 1'b0;
    s_grant = 1'b0; s_vi = '0; s_vj = '0; s_imm = '0; s_pc = '0; s_op = '0;
    s_typ = '0; s_tag = '0;
    #12;
    chk("rst_ready", {31'b0, alu_ready}, 32'd0);
    chk("rst_full", {31'b0, alu_full}, 32'd0);
    chk("rst_result", alu_result, 32'd0);
    chk("rst_next_pc", next_pc, 32'd0);
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;

    // spec examples with immediate grant
    s_grant = 1'b1;
    issue(7'b0110011, 3'd0, 1'b0, 32'd7, 32'd5, 32'd0, 32'h1000, 5'd3);
    issue(7'b0110011, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 32'h1004, 5'd4);
    issue(7'b0110011, 3'd5, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'h1008, 5'd5);
    issue(7'b1100011, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 5'd6);
    issue(7'b1100111, 3'd0, 1'b0, 32'h203, 32'd0, 32'd2, 32'h40, 5'd7);
    issue(7'b0110011, 3'd0, 1'b1, 32'd3, 32'd5, 32'd0, 32'h200, 5'd8);
    issue(7'b1100011, 3'd2, 1'b0, 32'd1, 32'd1, 32'd16, 32'h300, 5'd9);
    tick();

    // back-pressure: third start while full is dropped
    s_grant = 1'b0;
    issue(7'b0010011, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'h10, 5'd1);
    issue(7'b0010011, 3'd0, 1'b0, 32'd2, 32'd2, 32'd0, 32'h14, 5'd2);
    issue(7'b0010011, 3'd0, 1'b0, 32'd3, 32'd3, 32'd0, 32'h18, 5'd3);
    s_grant = 1'b1;
    tick();
    tick();
    s_grant = 1'b0;

    // flush beats simultaneous start and grant
    issue(7'b0110111, 3'd0, 1'b0, 32'd0, 32'd0, 32'hABCD_0000, 32'h20, 5'd10);
    issue(7'b1101111, 3'd0, 1'b0, 32'd0, 32'd0, 32'h40, 32'h24, 5'd11);
    s_flush = 1'b1; s_grant = 1'b1;
    issue(7'b0110011, 3'd4, 1'b0, 32'd9, 32'd6, 32'd0, 32'h28, 5'd12);
    s_flush = 1'b0; s_grant = 1'b0;
    tick();

    // asynchronous reset in the middle of a cycle
    issue(7'b0010111, 3'd0, 1'b0, 32'd0, 32'd0, 32'h1000, 32'h500, 5'd13);
    issue(7'b0010011, 3'd7, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'h504, 5'd14);
    #1 rst_in = 1'b0;
    #1;
    q.delete();
    cur_cnt = 0;
    chk("arst_ready", {31'b0, alu_ready}, 32'd0);
    chk("arst_full", {31'b0, alu_full}, 32'd0);
    chk("arst_tag", {27'b0, fin_tag}, 32'd0);
    chk("arst_result", alu_result, 32'd0);
    chk("arst_next_pc", next_pc, 32'd0);
    chk("arst_is_ctrl", {31'b0, is_ctrl}, 32'd0);
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;

    // random traffic with freezes and occasional flushes
    for (int n = 0; n < 500; n++) begin
      s_rdy   = ($urandom % 8) != 0;
      s_flush = ($urandom % 40) == 0;
      s_grant = ($urandom % 2) != 0;
      s_start = (cur_cnt != 2) && (($urandom % 4) != 0);
      s_typ   = opcs[$urandom % 8];
      s_op    = 3'($urandom);
      s_add   = 1'($urandom);
      s_vi    = ($urandom % 4 == 0) ? 32'($urandom % 4) : $urandom;
      s_vj    = ($urandom % 4 == 0) ? s_vi : $urandom;
      s_imm   = $urandom;
      s_pc    = $urandom & ~32'h3;
      s_tag   = 5'($urandom);
      tick();
    end

    s_start = 1'b0; s_flush = 1'b0; s_rdy = 1'b1; s_grant = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
